// File: rtl/alert_ping_pkg.sv
// ----------------------------------------------------------------------------
// alert_ping_pkg
//
// Shared definitions for the alert ping scheduler:
//   state_e      - scheduler FSM states (Idle, Wait, Ping, Fail)
//   DefNAlerts   - default number of pinged alert channels
//   DefCntWidth  - default width of the wait / ack-window counter
// ----------------------------------------------------------------------------
package alert_ping_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StPing = 2'd2,
        StFail = 2'd3
    } state_e;

    localparam int DefNAlerts  = 4;
    localparam int DefCntWidth = 16;

endpackage

// File: rtl/alert_ping_sel.sv
// ----------------------------------------------------------------------------
// alert_ping_sel
//
// Combinational round-robin picker. Starting at last_idx+1 and wrapping to 0,
// it returns the first channel whose mask bit is set. last_idx itself is
// examined last, so it only wins when it is the sole enabled channel.
//
// Ports:
//   mask     in   NAlerts  per-channel enable
//   last_idx in   IdxW     index of the most recently pinged channel
//   idx      out  IdxW     selected channel (equals last_idx when !valid)
//   valid    out  1        at least one channel is enabled
// ----------------------------------------------------------------------------
module alert_ping_sel
    import alert_ping_pkg::*;
#(
    parameter int NAlerts = DefNAlerts
) (
    input  logic [NAlerts-1:0]         mask,
    input  logic [$clog2(NAlerts)-1:0] last_idx,
    output logic [$clog2(NAlerts)-1:0] idx,
    output logic                       valid
);

    localparam int IdxW = $clog2(NAlerts);

    int              cand_w;
    logic [IdxW-1:0] cand;

    always_comb begin
        idx    = last_idx;
        valid  = 1'b0;
        cand_w = 0;
        cand   = '0;
        // Offsets 1..NAlerts: offset NAlerts lands back on last_idx, which
        // gives it the lowest priority of all channels.
        for (int off = 1; off <= NAlerts; off++) begin
            cand_w = int'(last_idx) + off;
            if (cand_w >= NAlerts) begin
                cand_w = cand_w - NAlerts;
            end
            cand = IdxW'(cand_w);
            if (!valid && mask[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alert_ping_sched.sv
// ----------------------------------------------------------------------------
// alert_ping_sched
//
// Periodically pings alert sender channels in round-robin order and flags a
// failure when a channel does not acknowledge within its ack window.
//
// Handshake: ping_req_o is a level that stays high on exactly one channel for
// every cycle the FSM is in Ping; the sender completes the handshake with a
// single-cycle ping_ok_i pulse on that same channel. Pulses on any other
// channel, or outside Ping, are ignored.
//
// Ports:
//   clk_i          in   1         clock, rising edge
//   rst_ni         in   1         asynchronous active-low reset
//   en_i           in   1         scheduler enable; low returns to Idle
//   alert_en_i     in   NAlerts   per-channel ping enable mask
//   wait_cyc_i     in   CntWidth  wait interval reload value
//   timeout_cyc_i  in   CntWidth  ack window reload value
//   ping_req_o     out  NAlerts   one-hot ping request level
//   ping_ok_i      in   NAlerts   per-channel ack pulse
//   ping_fail_o    out  1         one-cycle pulse on ack timeout
//   fail_idx_o     out  IdxW      failing channel; holds between pulses
//   state_o        out  state_e   current FSM state (debug)
//
// Timing: the Wait state lasts wait_cyc_i+1 cycles (counter runs N..0), the
// ack window lasts timeout_cyc_i+1 cycles. All outputs come from registers.
// ----------------------------------------------------------------------------
module alert_ping_sched
    import alert_ping_pkg::*;
#(
    parameter int NAlerts  = DefNAlerts,
    parameter int CntWidth = DefCntWidth
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic [NAlerts-1:0]         alert_en_i,
    input  logic [CntWidth-1:0]        wait_cyc_i,
    input  logic [CntWidth-1:0]        timeout_cyc_i,
    output logic [NAlerts-1:0]         ping_req_o,
    input  logic [NAlerts-1:0]         ping_ok_i,
    output logic                       ping_fail_o,
    output logic [$clog2(NAlerts)-1:0] fail_idx_o,
    output state_e                     state_o
);

    localparam int IdxW = $clog2(NAlerts);

    // Reset value of last_idx: the channel "before" channel 0, so the first
    // ping after reset goes to channel 0.
    localparam logic [IdxW-1:0] LastRst = IdxW'(NAlerts - 1);

    state_e                state_q,    state_d;
    logic [CntWidth-1:0]   cnt_q,      cnt_d;
    logic [IdxW-1:0]       last_q,     last_d;
    logic [NAlerts-1:0]    req_q,      req_d;
    logic                  fail_q,     fail_d;
    logic [IdxW-1:0]       fail_idx_q, fail_idx_d;

    logic [IdxW-1:0]       sel_idx;
    logic                  sel_valid;
    logic                  cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    alert_ping_sel #(
        .NAlerts (NAlerts)
    ) u_sel (
        .mask     (alert_en_i),
        .last_idx (last_q),
        .idx      (sel_idx),
        .valid    (sel_valid)
    );

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            last_q     <= LastRst;
            req_q      <= '0;
            fail_q     <= 1'b0;
            fail_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            req_q      <= req_d;
            fail_q     <= fail_d;
            fail_idx_q <= fail_idx_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output logic
    //
    // req_d and fail_d default to 0, so every transition that does not
    // explicitly keep a request alive drops it, and the fail pulse can only
    // last the single cycle spent in Fail.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        req_d      = '0;
        fail_d     = 1'b0;
        fail_idx_d = fail_idx_q;

        if (!en_i) begin
            // Disable wins over everything, including a timeout due this
            // cycle; last_idx is kept so the rotation resumes where it left.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StWait;
                    cnt_d   = wait_cyc_i;
                end

                StWait: begin
                    if (!cnt_zero) begin
                        cnt_d = cnt_q - CntWidth'(1);
                    end else if (sel_valid) begin
                        state_d        = StPing;
                        last_d         = sel_idx;
                        cnt_d          = timeout_cyc_i;
                        req_d[sel_idx] = 1'b1;
                    end else begin
                        // Nothing enabled: start another wait period.
                        cnt_d = wait_cyc_i;
                    end
                end

                StPing: begin
                    // The ack is checked before the timeout so an ack on the
                    // last window cycle still counts.
                    if (ping_ok_i[last_q]) begin
                        state_d = StWait;
                        cnt_d   = wait_cyc_i;
                    end else if (cnt_zero) begin
                        state_d    = StFail;
                        fail_d     = 1'b1;
                        fail_idx_d = last_q;
                    end else begin
                        cnt_d         = cnt_q - CntWidth'(1);
                        req_d[last_q] = 1'b1;
                    end
                end

                StFail: begin
                    state_d = StWait;
                    cnt_d   = wait_cyc_i;
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    assign ping_req_o  = req_q;
    assign ping_fail_o = fail_q;
    assign fail_idx_o  = fail_idx_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_alert_ping_sched.sv
// ----------------------------------------------------------------------------
// tb_alert_ping_sched
//
// Directed scenarios followed by a randomized run. Expected behaviour comes
// from a transaction-level model: each ping is described by the channel the
// round-robin rule picks, the length of the preceding wait gap (wait+1),
// the ping length (ack cycle + 1, or timeout + 1) and whether it ends in a
// fail pulse naming that channel.
// ----------------------------------------------------------------------------
module tb_alert_ping_sched;
    import alert_ping_pkg::*;

    localparam int NA = 4;
    localparam int CW = 16;

    logic              clk;
    logic              rst_n;
    logic              en;
    logic [NA-1:0]     alert_en;
    logic [CW-1:0]     wait_cyc;
    logic [CW-1:0]     timeout_cyc;
    logic [NA-1:0]     ping_req;
    logic [NA-1:0]     ping_ok;
    logic              ping_fail;
    logic [1:0]        fail_idx;
    state_e            state;

    int n_cmp;
    int n_err;
    int model_last;
    int reload_wait;

    alert_ping_sched #(
        .NAlerts  (NA),
        .CntWidth (CW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en),
        .alert_en_i    (alert_en),
        .wait_cyc_i    (wait_cyc),
        .timeout_cyc_i (timeout_cyc),
        .ping_req_o    (ping_req),
        .ping_ok_i     (ping_ok),
        .ping_fail_o   (ping_fail),
        .fail_idx_o    (fail_idx),
        .state_o       (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    // Inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NA-1:0] onehot(input int c);
        logic [NA-1:0] v;
        v = '0;
        if (c >= 0 && c < NA) v[c] = 1'b1;
        return v;
    endfunction

    // Round-robin rule: first enabled channel after 'last', wrapping; 'last'
    // itself only if nothing else is enabled.
    function automatic int model_next(input logic [NA-1:0] m, input int last);
        for (int off = 1; off <= NA; off++) begin
            int c;
            c = (last + off) % NA;
            if (m[c]) return c;
        end
        return -1;
    endfunction

    // Count quiet cycles until a request appears and check channel + gap.
    task automatic wait_req(input string tag, input int exp_ch, input bit noise);
        int gap;
        gap = 0;
        while (ping_req === '0 && gap < 300) begin
            chk({tag, ":gap_nofail"}, 32'(ping_fail), 32'(0));
            gap++;
            ping_ok = noise ? NA'($urandom) : '0;
            step();
        end
        ping_ok = '0;
        chk({tag, ":gap_len"}, 32'(gap), 32'(reload_wait + 1));
        chk({tag, ":req"}, 32'(ping_req), 32'(onehot(exp_ch)));
        chk({tag, ":state_ping"}, 32'(state), 32'(StPing));
    endtask

    // One complete ping transaction.
    task automatic do_ping(input string tag, input logic [NA-1:0] mask, input int ack_at,
                           input int ack_ch, input bit noise, input bit clr);
        int  exp_ch;
        int  tmo;
        int  ping_len;
        bit  acked;
        alert_en = mask;
        tmo      = int'(timeout_cyc);
        exp_ch   = model_next(mask, model_last);
        wait_req(tag, exp_ch, noise);
        acked    = (ack_ch == exp_ch) && (ack_at <= tmo);
        ping_len = acked ? ack_at + 1 : tmo + 1;
        for (int k = 0; k < ping_len; k++) begin
            if (k > 0) chk({tag, ":req_hold"}, 32'(ping_req), 32'(onehot(exp_ch)));
            chk({tag, ":ping_nofail"}, 32'(ping_fail), 32'(0));
            // Removing the pinged channel from the mask must not abort it.
            if (clr) alert_en = mask & ~onehot(exp_ch);
            ping_ok = (k == ack_at) ? onehot(ack_ch) : '0;
            step();
        end
        ping_ok  = '0;
        alert_en = mask;
        chk({tag, ":req_drop"}, 32'(ping_req), 32'(0));
        if (!acked) begin
            chk({tag, ":fail_pulse"}, 32'(ping_fail), 32'(1));
            chk({tag, ":fail_idx"}, 32'(fail_idx), 32'(exp_ch));
            step();
            chk({tag, ":fail_idx_hold"}, 32'(fail_idx), 32'(exp_ch));
        end
        chk({tag, ":after_nofail"}, 32'(ping_fail), 32'(0));
        model_last  = exp_ch;
        reload_wait = int'(wait_cyc);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int exp_ch;
        n_cmp       = 0;
        n_err       = 0;
        rst_n       = 1'b0;
        en          = 1'b0;
        alert_en    = '0;
        wait_cyc    = CW'(3);
        timeout_cyc = CW'(5);
        ping_ok     = '0;
        model_last  = NA - 1;
        reload_wait = 3;

        // Reset state
        #1;
        chk("rst:req", 32'(ping_req), 32'(0));
        chk("rst:fail", 32'(ping_fail), 32'(0));
        chk("rst:fail_idx", 32'(fail_idx), 32'(0));
        chk("rst:state", 32'(state), 32'(StIdle));
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("idle_disabled:state", 32'(state), 32'(StIdle));
        chk("idle_disabled:req", 32'(ping_req), 32'(0));

        // All enabled, immediate acks: ch0,1,2,3,0 with 4-cycle gaps
        en = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            do_ping($sformatf("rr%0d", i), 4'b1111, 0, model_next(4'b1111, model_last), 0, 0);
        end

        // Mask 1010, no acks: ch1 then ch3 time out
        do_ping("tmo_ch1", 4'b1010, 99, 1, 0, 0);
        do_ping("tmo_ch3", 4'b1010, 99, 3, 0, 0);

        // Ack on the last window cycle wins over the timeout
        do_ping("ack_last", 4'b1111, 5, 0, 0, 0);
        do_ping("after_ack_last", 4'b1111, 0, 1, 0, 0);

        // Ack on a non-requested channel is ignored -> ch0 fails
        do_ping("wrong_ack", 4'b0001, 2, 2, 0, 0);

        // en dropped mid-ping
        alert_en = 4'b1111;
        exp_ch   = model_next(4'b1111, model_last);
        wait_req("en_drop", exp_ch, 0);
        step();
        chk("en_drop:req_cycle1", 32'(ping_req), 32'(onehot(exp_ch)));
        en = 1'b0;
        step();
        chk("en_drop:req_off", 32'(ping_req), 32'(0));
        chk("en_drop:state", 32'(state), 32'(StIdle));
        for (int i = 0; i < 10; i++) begin
            chk("en_drop:nofail", 32'(ping_fail | (|ping_req)), 32'(0));
            step();
        end
        model_last  = exp_ch;
        en          = 1'b1;
        reload_wait = int'(wait_cyc);
        step();
        do_ping("resume", 4'b1111, 0, model_next(4'b1111, model_last), 0, 0);

        // Reset pulsed mid-ping
        exp_ch = model_next(4'b1111, model_last);
        wait_req("rst_mid", exp_ch, 0);
        step();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid:req_async", 32'(ping_req), 32'(0));
        chk("rst_mid:state", 32'(state), 32'(StIdle));
        step();
        step();
        rst_n = 1'b1;
        model_last  = NA - 1;
        reload_wait = int'(wait_cyc);
        step();
        chk("rst_mid:fail_idx_rst", 32'(fail_idx), 32'(0));
        do_ping("after_rst", 4'b1111, 1, 0, 0, 0);

        // No channel enabled for 3 wait periods, then ch2 only
        alert_en = '0;
        for (int i = 0; i < 3 * (int'(wait_cyc) + 1); i++) begin
            chk("mask_zero:quiet", 32'({ping_fail, ping_req}), 32'(0));
            step();
        end
        do_ping("mask_ch2", 4'b0100, 0, 2, 0, 0);

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            logic [NA-1:0] m;
            int            ack_at;
            int            ack_ch;
            wait_cyc    = CW'($urandom_range(0, 4));
            timeout_cyc = CW'($urandom_range(0, 6));
            m           = NA'($urandom_range(1, (1 << NA) - 1));
            ack_at      = $urandom_range(0, int'(timeout_cyc) + 2);
            ack_ch      = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NA - 1))
                                                      : model_next(m, model_last);
            do_ping($sformatf("rnd%0d", i), m, ack_at, ack_ch,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alert_ping_sched.md
ALERT_PING_SCHED -- requirements
Module: alert_ping_sched

Interface
REQ-001 SHALL have parameter NAlerts, default 4, number of alert sender channels pinged (2..32).
REQ-002 SHALL have parameter CntWidth, default 16, width of the wait and timeout counters.
REQ-003 SHALL have port clk_i  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port en_i  input  1  scheduler enable; low forces Idle.
REQ-006 SHALL have port alert_en_i  input  NAlerts  per-channel ping enable mask.
REQ-007 SHALL have port wait_cyc_i  input  CntWidth  wait-interval reload value.
REQ-008 SHALL have port timeout_cyc_i  input  CntWidth  ack-window reload value.
REQ-009 SHALL have port ping_req_o  output  NAlerts  one-hot ping request, level, to the alert senders.
REQ-010 SHALL have port ping_ok_i  input  NAlerts  per-channel ping handshake complete, single-cycle pulse.
REQ-011 SHALL have port ping_fail_o  output  1  single-cycle pulse on ping timeout.
REQ-012 SHALL have port fail_idx_o  output  $clog2(NAlerts)  failing channel index; valid while ping_fail_o is high, holds otherwise.

Function
REQ-013 SHALL implement FSM states Idle, Wait, Ping, Fail; all outputs driven from registers.
REQ-014 Idle: SHALL move to Wait when en_i=1, loading cnt with wait_cyc_i.
REQ-015 Wait: SHALL decrement cnt each cycle; at cnt==0 it SHALL select the next channel and evaluate REQ-016/017, giving a gap of wait_cyc_i+1 cycles in Wait.
REQ-016 Selection: SHALL be round-robin, searching from last_idx+1 upward with wrap to 0, picking the first channel with alert_en_i=1; last_idx itself is eligible only if no other channel is enabled.
REQ-017 If alert_en_i is all-zero at cnt==0, SHALL stay in Wait and reload cnt with wait_cyc_i; no request or fail.
REQ-018 On selection, SHALL enter Ping, set last_idx to the selected index and load cnt with timeout_cyc_i.
REQ-019 Ping: ping_req_o[last_idx] SHALL be 1 in every cycle state_q==Ping; all other bits 0.
REQ-020 Ping: ping_ok_i[last_idx]=1 SHALL return to Wait with cnt reloaded with wait_cyc_i.
REQ-021 Ping: with no ack and cnt==0, SHALL enter Fail; ack window = timeout_cyc_i+1 cycles.
REQ-022 Ack and timeout in the same cycle: the ack SHALL win; no fail.
REQ-023 ping_ok_i bits of non-requested channels, or any bit outside Ping, SHALL be ignored.
REQ-024 Fail: SHALL assert ping_fail_o for exactly one cycle with fail_idx_o=last_idx, then enter Wait with cnt reloaded.
REQ-025 Clearing alert_en_i[last_idx] during Ping SHALL NOT abort the ping.
REQ-026 en_i=0 in any state SHALL enter Idle next cycle, drop ping_req_o and keep last_idx; a pending timeout SHALL NOT produce a fail.
REQ-027 Counters SHALL saturate at 0 and never wrap; wait_cyc_i and timeout_cyc_i are sampled only at reload.

Reset
REQ-028 While rst_ni=0: state_q=Idle, cnt=0, last_idx=NAlerts-1 (first ping goes to channel 0), ping_req_o=0, ping_fail_o=0, fail_idx_o=0.
REQ-029 Reset asserted mid-Ping SHALL clear ping_req_o asynchronously; no fail pulse after release.

Structure
REQ-030 state_e enum and default-width localparams SHALL live in shared package alert_ping_pkg.
REQ-031 The round-robin next-index search SHALL be the combinational sub-module alert_ping_sel (inputs mask, last_idx; outputs idx, valid).

Verification
REQ-032 NAlerts=4, all enabled, wait=3, timeout=5, immediate acks -> req order ch0,ch1,ch2,ch3,ch0; 4 Wait cycles between pings.
REQ-033 alert_en_i=4'b1010, timeout=5, no acks -> ch1 ping 6 cycles, fail pulse fail_idx_o=1, then ch3 ping, fail_idx_o=3.
REQ-034 ack on the final window cycle (cnt==0) -> no ping_fail_o; next ping proceeds normally.
REQ-035 ping_ok_i[2] while ch0 requested -> ignored; ch0 times out and fails with fail_idx_o=0.
REQ-036 en_i dropped mid-Ping, or rst_ni pulsed mid-Ping -> ping_req_o=0 next cycle (immediately on reset), no fail; after re-enable the scheduler resumes at last_idx+1, or at ch0 after reset.
REQ-037 alert_en_i=0 for 3 wait periods -> no req and no fail; enabling ch2 -> ch2 pinged at the next wait expiry.
